// File: rtl/eeg_pea_eng_oarb.sv
// Output arbiter for a row of EEG PEs: round-robin merge of the per-PE output streams
// onto the single ORAM write port, with per-PE address translation and layer-done tracking.
module eeg_pea_eng_oarb #(
  parameter int PE_NUM      = 4,
  parameter int DATA_OUT_DW = 8,
  parameter int OMUX_ADD_AW = 8,
  parameter int ORAM_ADD_AW = 10,
  parameter int PE_IDX_AW   = (PE_NUM > 1) ? $clog2(PE_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          CFG_START,
  input  logic [PE_NUM-1:0]             CFG_PE_MSK,
  input  logic [ORAM_ADD_AW-1:0]        CFG_OADD_BASE,
  input  logic [ORAM_ADD_AW-1:0]        CFG_OADD_STR,
  input  logic [PE_NUM-1:0]             PE_OUT_VLD,
  input  logic [PE_NUM-1:0]             PE_OUT_LST,
  input  logic [PE_NUM*OMUX_ADD_AW-1:0] PE_OUT_ADD,
  input  logic [PE_NUM*DATA_OUT_DW-1:0] PE_OUT_DAT,
  output logic [PE_NUM-1:0]             PE_OUT_RDY,
  output logic                          ORAM_WR_VLD,
  output logic [ORAM_ADD_AW-1:0]        ORAM_WR_ADD,
  output logic [DATA_OUT_DW-1:0]        ORAM_WR_DAT,
  input  logic                          ORAM_WR_RDY,
  output logic                          DONE,
  output logic                          IS_IDLE,
  output logic                          ERR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [PE_NUM-1:0]      mask_reg;
  logic [PE_NUM-1:0]      done_reg;
  logic [PE_IDX_AW-1:0]   rr_ptr_reg;
  logic [ORAM_ADD_AW-1:0] off_reg [PE_NUM];
  logic                   wr_vld_reg;
  logic [ORAM_ADD_AW-1:0] wr_add_reg;
  logic [DATA_OUT_DW-1:0] wr_dat_reg;
  logic                   err_reg;

  logic [OMUX_ADD_AW-1:0] pe_add [PE_NUM];
  logic [DATA_OUT_DW-1:0] pe_dat [PE_NUM];
  logic [ORAM_ADD_AW-1:0] pe_loc [PE_NUM];

  logic                   run;
  logic                   adv;
  logic                   start_go;
  logic                   all_done;
  logic                   bad_beat;
  logic                   accept;
  logic [PE_NUM-1:0]      elig;
  logic                   gnt_found;
  logic [PE_IDX_AW-1:0]   gnt_idx;
  logic [PE_IDX_AW-1:0]   rr_ptr_next;
  logic [ORAM_ADD_AW-1:0] wr_add_next;

  // Unpack the PE buses and widen each local address to the ORAM address width.
  genvar gi;
  generate
    for (gi = 0; gi < PE_NUM; gi++) begin : g_pe
      assign pe_add[gi] = PE_OUT_ADD[gi*OMUX_ADD_AW +: OMUX_ADD_AW];
      assign pe_dat[gi] = PE_OUT_DAT[gi*DATA_OUT_DW +: DATA_OUT_DW];
      if (OMUX_ADD_AW >= ORAM_ADD_AW) begin : g_trunc
        assign pe_loc[gi] = pe_add[gi][ORAM_ADD_AW-1:0];
      end else begin : g_ext
        assign pe_loc[gi] = {{(ORAM_ADD_AW-OMUX_ADD_AW){1'b0}}, pe_add[gi]};
      end
    end
  endgenerate

  assign run      = (state_reg == ST_RUN);
  assign adv      = ~wr_vld_reg | ORAM_WR_RDY;
  assign start_go = (state_reg == ST_IDLE) & CFG_START;
  assign all_done = &(done_reg | ~mask_reg);
  assign bad_beat = run & (|(PE_OUT_VLD & (~mask_reg | done_reg)));
  assign elig     = PE_OUT_VLD & mask_reg & ~done_reg;

  // Round-robin: lowest eligible index at or above the pointer, else lowest overall.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = PE_NUM - 1; i >= 0; i--) begin
      if (elig[i] && (PE_IDX_AW'(i) >= rr_ptr_reg)) begin
        gnt_found = 1'b1;
        gnt_idx   = PE_IDX_AW'(i);
      end
    end
    if (!gnt_found) begin
      for (int i = PE_NUM - 1; i >= 0; i--) begin
        if (elig[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = PE_IDX_AW'(i);
        end
      end
    end
  end

  assign accept      = run & adv & gnt_found;
  assign rr_ptr_next = (gnt_idx == PE_IDX_AW'(PE_NUM - 1)) ? '0 : gnt_idx + PE_IDX_AW'(1);
  assign wr_add_next = off_reg[gnt_idx] + pe_loc[gnt_idx];

  always_comb begin
    PE_OUT_RDY = '0;
    if (accept) begin
      PE_OUT_RDY[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    DONE       = 1'b0;
    IS_IDLE    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        IS_IDLE = 1'b1;
        if (CFG_START) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Only finish once the final beat has left the output register.
        if (all_done && adv) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        DONE       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Per-PE base offsets are ready by the first RUN cycle, keeping the multiply off the grant path.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg <= '0;
      done_reg <= '0;
      for (int i = 0; i < PE_NUM; i++) begin
        off_reg[i] <= '0;
      end
    end else if (start_go) begin
      mask_reg <= CFG_PE_MSK;
      done_reg <= '0;
      for (int i = 0; i < PE_NUM; i++) begin
        off_reg[i] <= CFG_OADD_BASE + ORAM_ADD_AW'(i) * CFG_OADD_STR;
      end
    end else if (accept && PE_OUT_LST[gnt_idx]) begin
      done_reg[gnt_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (accept) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_reg <= 1'b0;
      wr_add_reg <= '0;
      wr_dat_reg <= '0;
    end else if (accept) begin
      wr_vld_reg <= 1'b1;
      wr_add_reg <= wr_add_next;
      wr_dat_reg <= pe_dat[gnt_idx];
    end else if (ORAM_WR_RDY) begin
      wr_vld_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (bad_beat) begin
      err_reg <= 1'b1;
    end
  end

  assign ORAM_WR_VLD = wr_vld_reg;
  assign ORAM_WR_ADD = wr_add_reg;
  assign ORAM_WR_DAT = wr_dat_reg;
  assign ERR         = err_reg;

endmodule

// File: tb/tb_eeg_pea_eng_oarb.sv
// Scoreboard bench for eeg_pea_eng_oarb: randomized PE streams, a rule-level reference
// model that queues expected ORAM writes, and an independent monitor that retires them.
module tb_eeg_pea_eng_oarb;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int LAW = 8;
  localparam int OAW = 10;

  typedef struct packed {
    logic           lst;
    logic [LAW-1:0] add;
    logic [DW-1:0]  dat;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             CFG_START;
  logic [N-1:0]     CFG_PE_MSK;
  logic [OAW-1:0]   CFG_OADD_BASE, CFG_OADD_STR;
  logic [N-1:0]     PE_OUT_VLD, PE_OUT_LST, PE_OUT_RDY;
  logic [N*LAW-1:0] PE_OUT_ADD;
  logic [N*DW-1:0]  PE_OUT_DAT;
  logic             ORAM_WR_VLD, ORAM_WR_RDY, DONE, IS_IDLE, ERR;
  logic [OAW-1:0]   ORAM_WR_ADD;
  logic [DW-1:0]    ORAM_WR_DAT;

  always #5 clk = ~clk;

  eeg_pea_eng_oarb #(.PE_NUM(N), .DATA_OUT_DW(DW), .OMUX_ADD_AW(LAW), .ORAM_ADD_AW(OAW)) dut (
    .clk(clk), .rst(rst), .CFG_START(CFG_START), .CFG_PE_MSK(CFG_PE_MSK),
    .CFG_OADD_BASE(CFG_OADD_BASE), .CFG_OADD_STR(CFG_OADD_STR),
    .PE_OUT_VLD(PE_OUT_VLD), .PE_OUT_LST(PE_OUT_LST), .PE_OUT_ADD(PE_OUT_ADD),
    .PE_OUT_DAT(PE_OUT_DAT), .PE_OUT_RDY(PE_OUT_RDY), .ORAM_WR_VLD(ORAM_WR_VLD),
    .ORAM_WR_ADD(ORAM_WR_ADD), .ORAM_WR_DAT(ORAM_WR_DAT), .ORAM_WR_RDY(ORAM_WR_RDY),
    .DONE(DONE), .IS_IDLE(IS_IDLE), .ERR(ERR)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // PE stream sources
  beat_t        pe_mem [N][32];
  int           pe_head [N];
  int           pe_tail [N];
  logic [N-1:0] pres = '0;
  logic [N-1:0] rogue = '0;
  logic [N-1:0] hs_vec = '0;
  int           vld_pct = 100;
  int           rdy_pct = 100;
  bit           rdy_hold_low = 1'b0;

  // Scoreboard: expected {addr,data}, plus a log of addresses actually written
  logic [OAW+DW-1:0] exp_q[$];
  int                wr_log[$];

  initial begin
    for (int i = 0; i < N; i++) begin
      pe_head[i] = 0;
      pe_tail[i] = 0;
    end
    PE_OUT_VLD = '0; PE_OUT_LST = '0; PE_OUT_ADD = '0; PE_OUT_DAT = '0;
    ORAM_WR_RDY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        beat_t b;
        if (rst) begin
          pe_head[i] = pe_tail[i];
          pres[i] = 1'b0;
        end else begin
          if (hs_vec[i]) begin
            pe_head[i]++;
            pres[i] = 1'b0;
          end
          if (!pres[i] && pe_head[i] != pe_tail[i] && $urandom_range(99) < vld_pct)
            pres[i] = 1'b1;
        end
        b = pres[i] ? pe_mem[i][pe_head[i]] : beat_t'($urandom);
        PE_OUT_VLD[i] = pres[i] | rogue[i];
        PE_OUT_LST[i] = pres[i] & b.lst;
        PE_OUT_ADD[i*LAW +: LAW] = b.add;
        PE_OUT_DAT[i*DW +: DW] = b.dat;
      end
      ORAM_WR_RDY = !rdy_hold_low && ($urandom_range(99) < rdy_pct);
    end
  end

  // Reference model: layer phase 0=idle, 1=running, 2=finish pulse
  int           m_phase, m_ptr, m_base, m_str;
  logic [N-1:0] m_mask, m_done;
  bit           m_vld, m_err;

  initial begin
    m_phase = 0; m_ptr = 0; m_base = 0; m_str = 0;
    m_mask = '0; m_done = '0; m_vld = 0; m_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_phase = 0; m_ptr = 0; m_base = 0; m_str = 0;
        m_mask = '0; m_done = '0; m_vld = 0; m_err = 0;
        exp_q.delete();
        hs_vec = '0;
      end else begin
        bit           running, can_take;
        logic [N-1:0] elig, exp_rdy, n_done;
        int           g, n_phase;
        running  = (m_phase == 1);
        can_take = !m_vld || ORAM_WR_RDY;
        elig     = PE_OUT_VLD & m_mask & ~m_done;
        g = -1;
        if (running && can_take)
          for (int k = 0; k < N; k++)
            if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        check("is_idle", IS_IDLE, m_phase == 0);
        check("done", DONE, m_phase == 2);
        check("wr_vld", ORAM_WR_VLD, m_vld);
        check("err", ERR, m_err);
        check("pe_rdy", PE_OUT_RDY, exp_rdy);
        hs_vec = PE_OUT_RDY & PE_OUT_VLD;

        if (running && |(PE_OUT_VLD & (~m_mask | m_done))) m_err = 1;
        n_done  = m_done;
        n_phase = m_phase;
        if (m_phase == 0 && CFG_START) begin
          n_phase = 1;
          m_mask  = CFG_PE_MSK;
          m_base  = CFG_OADD_BASE;
          m_str   = CFG_OADD_STR;
          n_done  = '0;
        end else if (m_phase == 1 && (m_done | ~m_mask) == '1 && can_take) begin
          n_phase = 2;
        end else if (m_phase == 2) begin
          n_phase = 0;
        end
        if (g >= 0) begin
          int a;
          a = (m_base + g * m_str + int'(PE_OUT_ADD[g*LAW +: LAW])) % (1 << OAW);
          exp_q.push_back({OAW'(a), PE_OUT_DAT[g*DW +: DW]});
          m_ptr = (g + 1) % N;
          if (PE_OUT_LST[g]) n_done[g] = 1'b1;
          m_vld = 1;
        end else if (ORAM_WR_RDY) begin
          m_vld = 0;
        end
        m_done  = n_done;
        m_phase = n_phase;
      end
    end
  end

  // Monitor: every presented write must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ORAM_WR_VLD) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_extra actual=0x%0h required=none t=%0t", ORAM_WR_ADD, $time);
        end else begin
          check("wr_add", ORAM_WR_ADD, exp_q[0][OAW+DW-1:DW]);
          check("wr_dat", ORAM_WR_DAT, exp_q[0][DW-1:0]);
          if (ORAM_WR_RDY) begin
            void'(exp_q.pop_front());
            wr_log.push_back(int'(ORAM_WR_ADD));
          end
        end
      end
    end
  end

  task automatic load(input logic [N-1:0] m, input int n, input bit seq);
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        pe_head[i] = 0;
        pe_tail[i] = n;
        for (int j = 0; j < n; j++) begin
          pe_mem[i][j].lst = (j == n - 1);
          pe_mem[i][j].add = seq ? LAW'(j) : LAW'($urandom_range(255));
          pe_mem[i][j].dat = DW'($urandom);
        end
      end
    end
  endtask

  task automatic start(input logic [N-1:0] m, input logic [OAW-1:0] base, input logic [OAW-1:0] str);
    @(posedge clk);
    #1;
    CFG_START = 1'b1; CFG_PE_MSK = m; CFG_OADD_BASE = base; CFG_OADD_STR = str;
    @(posedge clk);
    #1;
    CFG_START = 1'b0;
    CFG_PE_MSK = N'($urandom); CFG_OADD_BASE = OAW'($urandom); CFG_OADD_STR = OAW'($urandom);
  endtask

  task automatic wait_done(input string name, input int limit, output int cycles);
    int left;
    cycles = 0;
    while (DONE !== 1'b1 && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    check(name, DONE, 1'b1);
    @(posedge clk);
    #2;
    left = 0;
    for (int i = 0; i < N; i++) left += pe_tail[i] - pe_head[i];
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_pe_left"}, left, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_vld", ORAM_WR_VLD, 1'b0);
    check("rst_add", ORAM_WR_ADD, '0);
    check("rst_dat", ORAM_WR_DAT, '0);
    check("rst_done", DONE, 1'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_rdy", PE_OUT_RDY, '0);
    check("rst_idle", IS_IDLE, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int cyc;
    CFG_START = 1'b0; CFG_PE_MSK = '0; CFG_OADD_BASE = '0; CFG_OADD_STR = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Abort mid-layer while a write is pending
    vld_pct = 100; rdy_pct = 60;
    load(4'hF, 20, 0);
    start(4'hF, 10'h055, 10'h011);
    cyc = 0;
    while (ORAM_WR_VLD !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t1_vld_seen", ORAM_WR_VLD, 1'b1);
    do_reset();
    repeat (4) @(posedge clk);

    // Full mask, three sequential beats per PE, round-robin order
    rdy_pct = 100;
    wr_log.delete();
    load(4'hF, 3, 1);
    start(4'hF, 10'h100, 10'h040);
    wait_done("t2_done", 200, cyc);
    check("t2_writes", wr_log.size(), 12);
    if (wr_log.size() == 12) begin
      check("t2_first", wr_log[0], 32'h100);
      check("t2_pe3b0", wr_log[3], 32'h1C0);
      check("t2_pe2b1", wr_log[6], 32'h181);
      check("t2_last", wr_log[11], 32'h1C2);
    end

    // Single enabled PE streams at one beat per cycle
    wr_log.delete();
    load(4'h2, 16, 1);
    start(4'h2, 10'h200, 10'h010);
    wait_done("t3_done", 200, cyc);
    check("t3_latency", cyc, 18);
    check("t3_writes", wr_log.size(), 16);

    // Output stall for five cycles with PE0 and PE3 pending
    wr_log.delete();
    load(4'h9, 10, 0);
    start(4'h9, 10'h020, 10'h033);
    repeat (3) @(posedge clk);
    #1 rdy_hold_low = 1'b1;
    repeat (5) @(posedge clk);
    #1 rdy_hold_low = 1'b0;
    wait_done("t4_done", 300, cyc);
    check("t4_writes", wr_log.size(), 20);

    // Empty mask finishes in two cycles; address wrap
    wr_log.delete();
    start(4'h0, 10'h123, 10'h045);
    wait_done("t6_done", 20, cyc);
    check("t6_latency", cyc, 2);
    check("t6_writes", wr_log.size(), 0);
    load(4'h2, 1, 1);
    pe_mem[1][0].add = 8'h30;
    start(4'h2, 10'h3F0, 10'h020);
    wait_done("t6w_done", 50, cyc);
    check("t6_wrap_n", wr_log.size(), 1);
    if (wr_log.size() == 1) check("t6_wrap", wr_log[0], 32'h040);

    // Random layers with a stray CFG_START pulse while running
    for (int r = 0; r < 10; r++) begin
      logic [N-1:0] m;
      m = N'($urandom);
      vld_pct = $urandom_range(100, 30);
      rdy_pct = $urandom_range(100, 30);
      load(m, $urandom_range(12, 1), 0);
      start(m, OAW'($urandom), OAW'($urandom));
      CFG_START = 1'b1;
      @(posedge clk);
      #1 CFG_START = 1'b0;
      wait_done("rnd_done", 1000, cyc);
    end

    // Disabled PE presenting beats raises sticky ERR
    vld_pct = 100; rdy_pct = 100;
    load(4'h5, 5, 0);
    rogue = 4'h2;
    start(4'h5, 10'h000, 10'h100);
    wait_done("t5_done", 200, cyc);
    check("t5_err", ERR, 1'b1);
    rogue = '0;
    repeat (3) @(posedge clk);
    do_reset();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eeg_pea_eng_oarb.md
Name: eeg_pea_eng_oarb

Overview:
Output arbiter/scheduler for a row of EEG_PEA_ENG_PE instances. It merges the PE_NUM per-PE output streams (valid/last/address/data) onto the single ORAM write port. Grants are round-robin, and each PE's local output address is translated to an absolute ORAM address. It tracks per-PE completion and pulses DONE when every enabled PE has delivered its last beat, so the engine sequencer can launch the next layer.

Parameters:
PE_NUM, 4, number of PE output streams arbitrated
DATA_OUT_DW, 8, PE output data width
OMUX_ADD_AW, 8, PE-local output address width
ORAM_ADD_AW, 10, ORAM write address width
PE_IDX_AW, $clog2(PE_NUM), grant index width (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
CFG_START  in  1  start pulse; CFG_* sampled when CFG_START=1 in IDLE
CFG_PE_MSK  in  PE_NUM  enabled-PE mask
CFG_OADD_BASE  in  ORAM_ADD_AW  ORAM base address of PE0
CFG_OADD_STR  in  ORAM_ADD_AW  ORAM address stride between consecutive PEs
PE_OUT_VLD  in  PE_NUM  per-PE output valid
PE_OUT_LST  in  PE_NUM  per-PE last beat of layer
PE_OUT_ADD  in  PE_NUM*OMUX_ADD_AW  packed PE-local addresses, PE i at [i*OMUX_ADD_AW +:OMUX_ADD_AW]
PE_OUT_DAT  in  PE_NUM*DATA_OUT_DW  packed PE data
PE_OUT_RDY  out  PE_NUM  per-PE ready (one-hot or zero)
ORAM_WR_VLD  out  1  write valid
ORAM_WR_ADD  out  ORAM_ADD_AW  absolute write address
ORAM_WR_DAT  out  DATA_OUT_DW  write data
ORAM_WR_RDY  in  1  ORAM accepts write
DONE  out  1  one-cycle pulse, all enabled PEs finished
IS_IDLE  out  1  FSM in IDLE
ERR  out  1  sticky: beat presented by a disabled or already-done PE

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high.
- Reset values: FSM=IDLE, ORAM_WR_VLD=0, ORAM_WR_ADD=0, ORAM_WR_DAT=0, DONE=0, ERR=0, PE_OUT_RDY=0, done mask=0, RR pointer=0, latched cfg=0. IS_IDLE=1 after reset.
- A reset asserted mid-layer aborts immediately. The pending output beat is dropped and no DONE is issued.
- FSM states: IDLE, RUN, FIN.
  - IDLE->RUN on CFG_START; latch mask, base and stride; clear done mask. CFG_START is ignored outside IDLE.
  - RUN->FIN when (done mask | ~mask)==all-ones and the output register is empty (ORAM_WR_VLD=0, or it is being accepted this cycle).
  - FIN->IDLE unconditionally. DONE=1 only while in FIN.
  - A mask of all-zero gives IDLE->RUN->FIN->IDLE; DONE is asserted 2 cycles after CFG_START.
- Eligible PE i: PE_OUT_VLD[i] & mask[i] & ~done[i].
- Grant: combinational round-robin, searched starting at the RR pointer. At most one PE is granted per cycle.
- Readiness: adv = ~ORAM_WR_VLD | ORAM_WR_RDY. PE_OUT_RDY[g] = RUN & adv. All other PE_OUT_RDY bits = 0.
- On an accepted beat from PE g:
  - RR pointer <= (g+1) mod PE_NUM.
  - ORAM_WR_VLD<=1.
  - ORAM_WR_DAT<=PE data.
  - ORAM_WR_ADD <= CFG_OADD_BASE + g*CFG_OADD_STR + zero-extended PE_OUT_ADD, truncated modulo 2^ORAM_ADD_AW (wrap allowed, no flag).
  - If PE_OUT_LST[g], set done[g].
- If ORAM_WR_RDY=1 and no beat is accepted, ORAM_WR_VLD<=0. If ORAM_WR_RDY=0, the output register holds all fields stable.
- Latency and throughput: a beat accepted in cycle t is presented on ORAM in t+1. Throughput is 1 beat/cycle with ORAM_WR_RDY held high.
- RR pointer is unchanged on cycles with no grant.
- ERR is set in RUN when PE_OUT_VLD[i] & (~mask[i] | done[i]). It is cleared only by rst. Such beats are never granted.
- Address arithmetic: the g*CFG_OADD_STR product is computed at ORAM_ADD_AW width. The base+offset term per PE is precomputed into PE_NUM registers at start, one cycle earlier than the first grant can occur.
- Simultaneous events:
  - LST beat accepted in the same cycle the last remaining PE completes: the FIN transition is taken once that output beat has been accepted by ORAM.
  - ORAM_WR_RDY=1 and a new grant in the same cycle: the register is reloaded with no bubble.

Test Plan:
1. Reset mid-RUN with ORAM_WR_VLD=1 -> next cycle all outputs at reset values, IS_IDLE=1, no DONE.
2. PE_NUM=4, mask=4'b1111, base=0x100, stride=0x40, every PE has 3 beats (local addr 0,1,2, LST on 2), ORAM_WR_RDY=1 -> 12 writes, grant order 0,1,2,3 repeating, PE2 beat1 at address 0x181; DONE one cycle after the last write is accepted.
3. Only PE1 valid continuously, mask=4'b0010 -> 1 beat/cycle, pointer cycling does not starve PE1, first write appears at t+1.
4. ORAM_WR_RDY low for 5 cycles while PE0 and PE3 are valid -> ORAM_WR_ADD/DAT stable, PE_OUT_RDY=0, no beats lost or duplicated.
5. mask=4'b0101 and PE1 asserts VLD -> ERR=1, PE_OUT_RDY[1] stays 0, DONE after PE0 and PE2 LST.
6. mask=0 with CFG_START -> DONE 2 cycles later with no writes. base=0x3F0, stride=0x20, local addr 0x30 on PE1 -> ORAM_WR_ADD=0x040 (wraps).
